enemy_tank_ai: RTL
==================

Name: enemy_tank_ai

Overview:
Autonomous controller that generates the move_up/move_down/move_left/move_right/fire command strobes for one enemy tank instance, in place of keyboard decode. It consumes that tank's blocked, position and bullet_active feedback plus the player position. It uses an LFSR-driven state machine to wander, chase, back off when blocked, and fire periodically or when aligned with the player. It instantiates once per enemy tank in the game top level and is clocked by frame_clk.

Parameters:
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
MIN_RUN, 16, minimum frames spent in MOVE per leg (8-bit).
BLOCK_LIMIT, 4, consecutive blocked frames before giving up on a leg (4-bit).
PAUSE_FRAMES, 8, idle frames after a blocked leg (8-bit).
FIRE_PERIOD, 60, frames between unconditional shots (8-bit).
ALIGN_WIN, 16, pixel tolerance for the aligned-shot test.

Ports:
frame_clk  input  1  frame clock; all state updates on its rising edge.
Reset  input  1  synchronous, active-high reset.
enable  input  1  AI run enable; 0 forces IDLE.
blocked  input  1  blocked feedback from the controlled tank for the current move command.
bullet_active  input  1  the controlled tank's bullet is in flight.
tank_x, tank_y  input  10 each  controlled tank top-left position.
target_x, target_y  input  10 each  player tank top-left position.
move_up, move_down, move_left, move_right  output  1 each  registered one-hot move command; all 0 when not moving.
fire  output  1  registered single-cycle fire pulse.
ai_state  output  2  current state, for debug: 0 IDLE, 1 TURN, 2 MOVE, 3 PAUSE.

Behaviour:
- Reset is sampled only on the frame_clk edge:
  - state=IDLE; all move outputs, fire and ai_state = 0.
  - lfsr=SEED; run_cnt, blk_cnt, pause_cnt, fire_cnt = 0; dir=up (0); last_blk_valid=0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right each frame_clk edge when not in reset, in every state.
- Direction encoding: 0 up, 1 down, 2 left, 3 right. The move output for dir is asserted iff state==MOVE; outputs are registered, so they change one edge after the state decision.
- IDLE: outputs 0. enable=1 -> TURN.
- TURN (exactly 1 cycle, outputs 0):
  - lfsr[1:0]==0 selects chase. dx=target_x-tank_x and dy=target_y-tank_y are 11-bit signed. If |dx|>=|dy|, pick right if dx>0, else left; otherwise pick down if dy>0, else up. dx=dy=0 picks up.
  - Otherwise dir=lfsr[3:2].
  - If last_blk_valid and the chosen dir equals last_blk_dir, use dir=(dir+1) mod 4. Then clear last_blk_valid.
  - run_cnt = MIN_RUN + lfsr[7:4], using 9-bit arithmetic with no overflow. Next state MOVE.
- MOVE:
  - run_cnt decrements each cycle.
  - blk_cnt increments while blocked=1 and clears when blocked=0; it saturates at 15.
  - If blk_cnt+blocked reaches BLOCK_LIMIT: last_blk_dir=dir, last_blk_valid=1, pause_cnt=PAUSE_FRAMES -> PAUSE. This check has priority over run expiry.
  - Else if run_cnt==1 -> TURN.
  - blk_cnt clears on MOVE entry.
- PAUSE: outputs 0; pause_cnt decrements; pause_cnt==1 -> TURN. PAUSE_FRAMES=0 is treated as 1.
- enable=0 in any state -> IDLE on the next edge, outputs 0 on that edge. Counters hold; fire_cnt clears.
- Fire logic is active in MOVE and PAUSE only:
  - fire_cnt increments each cycle and saturates at 255.
  - fire=1 for one cycle when bullet_active=0 and fire was 0 last cycle, and either:
    - fire_cnt>=FIRE_PERIOD, or
    - fire_cnt>=FIRE_PERIOD/4 and the player is aligned in the facing dir.
  - Aligned means:
    - up/down: |dx|<ALIGN_WIN and dy<0 (up) or dy>0 (down).
    - left/right: |dy|<ALIGN_WIN and dx<0 (left) or dx>0 (right).
  - fire_cnt clears on the cycle fire asserts.
  - If bullet_active=1, no fire; the counter keeps saturating.
- Simultaneous events: enable=0 overrides all; Reset overrides enable. Never more than one move output high. fire is never high on two consecutive edges.

Test Plan:
1. Reset=1 for 2 cycles with SEED=16'h0000 -> lfsr==16'hACE1, all outputs 0, ai_state=0; then enable=1 -> ai_state 1 then 2 on successive edges, exactly one move output high.
2. Force chase (seed chosen so lfsr[1:0]==0 in TURN), tank=(100,200), target=(300,210) -> move_right=1; run length equals MIN_RUN+lfsr[7:4] frames, then TURN.
3. In MOVE, hold blocked=1 -> after 4 frames ai_state=3, moves 0 for 8 frames; the next TURN never selects the blocked dir.
4. MOVE with dir=up, target directly above (dx=5, dy=-100), bullet_active=0 -> fire pulses at fire_cnt=15; with bullet_active=1, no fire until it drops.
5. Unaligned target, bullet_active=0 -> fire pulse every 61 frames; each pulse is exactly 1 cycle wide.
6. enable dropped mid-MOVE -> next edge ai_state=0, all outputs 0; Reset asserted mid-PAUSE -> full reset values on that edge.

Source files
------------

// File: rtl/enemy_tank_ai.sv
// Enemy tank controller: LFSR-driven wander/chase state machine that produces
// registered move strobes and a single-cycle fire pulse for one tank.
module enemy_tank_ai #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [7:0]  MIN_RUN      = 8'd16,
  parameter logic [3:0]  BLOCK_LIMIT  = 4'd4,
  parameter logic [7:0]  PAUSE_FRAMES = 8'd8,
  parameter logic [7:0]  FIRE_PERIOD  = 8'd60,
  parameter logic [10:0] ALIGN_WIN    = 11'd16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       blocked,
  input  logic       bullet_active,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic [1:0] ai_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, MOVE = 2'd2, PAUSE = 2'd3} state_t;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

  localparam logic [15:0] SEED_EFF     = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [7:0]  PAUSE_LOAD   = (PAUSE_FRAMES == 8'd0) ? 8'd1 : PAUSE_FRAMES;
  localparam logic [7:0]  FIRE_QUARTER = {2'b00, FIRE_PERIOD[7:2]};

  state_t      state, state_n;
  dir_t        dir, dir_n, last_blk_dir, last_blk_dir_n, chase_dir, turn_dir;
  logic        last_blk_valid, last_blk_valid_n;
  logic [15:0] lfsr, lfsr_n;
  logic [8:0]  run_cnt, run_cnt_n;
  logic [3:0]  blk_cnt, blk_cnt_n;
  logic [4:0]  blk_sum;
  logic [7:0]  pause_cnt, pause_cnt_n, fire_cnt, fire_cnt_n;
  logic        fire_n, aligned;

  // Signed offsets from this tank to the player, and their magnitudes.
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               dx_pos, dx_neg, dy_pos, dy_neg;

  assign dx     = $signed({1'b0, target_x}) - $signed({1'b0, tank_x});
  assign dy     = $signed({1'b0, target_y}) - $signed({1'b0, tank_y});
  assign adx    = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady    = dy[10] ? $unsigned(-dy) : $unsigned(dy);
  assign dx_neg = dx[10];
  assign dy_neg = dy[10];
  assign dx_pos = !dx[10] && (dx != 11'sd0);
  assign dy_pos = !dy[10] && (dy != 11'sd0);
  assign blk_sum = {1'b0, blk_cnt} + {4'd0, blocked};

  always_comb begin
    if (!dx_pos && !dx_neg && !dy_pos && !dy_neg) chase_dir = DIR_UP;
    else if (adx >= ady)                          chase_dir = dx_pos ? DIR_RIGHT : DIR_LEFT;
    else                                          chase_dir = dy_pos ? DIR_DOWN : DIR_UP;
  end

  // Never re-pick the direction that just got us stuck.
  always_comb begin
    turn_dir = (lfsr[1:0] == 2'b00) ? chase_dir : dir_t'(lfsr[3:2]);
    if (last_blk_valid && (turn_dir == last_blk_dir)) turn_dir = dir_t'(turn_dir + 2'd1);
  end

  always_comb begin
    case (dir)
      DIR_UP:   aligned = (adx < ALIGN_WIN) && dy_neg;
      DIR_DOWN: aligned = (adx < ALIGN_WIN) && dy_pos;
      DIR_LEFT: aligned = (ady < ALIGN_WIN) && dx_neg;
      default:  aligned = (ady < ALIGN_WIN) && dx_pos;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_n          = state;
    dir_n            = dir;
    last_blk_dir_n   = last_blk_dir;
    last_blk_valid_n = last_blk_valid;
    run_cnt_n        = run_cnt;
    blk_cnt_n        = blk_cnt;
    pause_cnt_n      = pause_cnt;
    fire_cnt_n       = fire_cnt;
    fire_n           = 1'b0;
    lfsr_n           = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    if (!enable) begin
      state_n    = IDLE;
      fire_cnt_n = 8'd0;
    end else begin
      if (state == MOVE || state == PAUSE) begin
        if (!bullet_active && !fire &&
            ((fire_cnt >= FIRE_PERIOD) || ((fire_cnt >= FIRE_QUARTER) && aligned))) begin
          fire_n     = 1'b1;
          fire_cnt_n = 8'd0;
        end else if (fire_cnt != 8'hFF) begin
          fire_cnt_n = fire_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: state_n = TURN;
        TURN: begin
          dir_n            = turn_dir;
          last_blk_valid_n = 1'b0;
          run_cnt_n        = {1'b0, MIN_RUN} + {5'd0, lfsr[7:4]};
          blk_cnt_n        = 4'd0;
          state_n          = MOVE;
        end
        MOVE: begin
          run_cnt_n = run_cnt - 9'd1;
          blk_cnt_n = blocked ? ((blk_cnt == 4'hF) ? blk_cnt : blk_cnt + 4'd1) : 4'd0;
          if (blk_sum >= {1'b0, BLOCK_LIMIT}) begin
            last_blk_dir_n   = dir;
            last_blk_valid_n = 1'b1;
            pause_cnt_n      = PAUSE_LOAD;
            state_n          = PAUSE;
          end else if (run_cnt <= 9'd1) begin
            state_n = TURN;
          end
        end
        PAUSE: begin
          pause_cnt_n = pause_cnt - 8'd1;
          if (pause_cnt <= 8'd1) state_n = TURN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state          <= IDLE;
      dir            <= DIR_UP;
      last_blk_dir   <= DIR_UP;
      last_blk_valid <= 1'b0;
      lfsr           <= SEED_EFF;
      run_cnt        <= 9'd0;
      blk_cnt        <= 4'd0;
      pause_cnt      <= 8'd0;
      fire_cnt       <= 8'd0;
      move_up        <= 1'b0;
      move_down      <= 1'b0;
      move_left      <= 1'b0;
      move_right     <= 1'b0;
      fire           <= 1'b0;
    end else begin
      state          <= state_n;
      dir            <= dir_n;
      last_blk_dir   <= last_blk_dir_n;
      last_blk_valid <= last_blk_valid_n;
      lfsr           <= lfsr_n;
      run_cnt        <= run_cnt_n;
      blk_cnt        <= blk_cnt_n;
      pause_cnt      <= pause_cnt_n;
      fire_cnt       <= fire_cnt_n;
      move_up        <= (state_n == MOVE) && (dir_n == DIR_UP);
      move_down      <= (state_n == MOVE) && (dir_n == DIR_DOWN);
      move_left      <= (state_n == MOVE) && (dir_n == DIR_LEFT);
      move_right     <= (state_n == MOVE) && (dir_n == DIR_RIGHT);
      fire           <= fire_n;
    end
  end

  assign ai_state = state;

endmodule
